// File: rtl/spi_ram_ctrl_pkg.sv
// Shared types and helpers for the SPI command-to-RAM controller.
package spi_ram_ctrl_pkg;

  localparam int SPI_WORD_W = 10;
  localparam int PAYLOAD_W  = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'b00,
    RC_FETCH = 2'b01,
    RC_HOLD  = 2'b10
  } ram_ctrl_state_e;

  // True when addr indexes a real RAM word; out-of-range writes are dropped
  // and out-of-range reads return zero.
  function automatic logic addr_in_range(input logic [PAYLOAD_W-1:0] addr,
                                         input int unsigned depth);
    return {{(32-PAYLOAD_W){1'b0}}, addr} < depth;
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_mem.sv
// Single-port synchronous RAM, registered read, write-first, no reset.
module spi_ram_mem
  import spi_ram_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [PAYLOAD_W-1:0] wdata,
  output logic [PAYLOAD_W-1:0] rdata
);

  logic [PAYLOAD_W-1:0] mem [MEM_DEPTH];

  // Write port and registered read; a same-cycle write is forwarded to the read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Consumes 10-bit SPI slave words {opcode, payload} and turns them into RAM
// accesses; read results are handed back on dout/tx_valid for MISO.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RC_IDLE  | no read outstanding, tx_valid low
//   RC_FETCH | RAM read in flight (issued on the RD_DATA accept cycle)
//   RC_HOLD  | dout/tx_valid presented until the next accepted command
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter bit WR_AUTOINC = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_WORD_W-1:0] din,
  input  logic                  rx_valid,
  output logic [PAYLOAD_W-1:0]  dout,
  output logic                  tx_valid
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_SIZE-1:0] WRAP_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  ram_ctrl_state_e      state, next_state;
  spi_cmd_e             cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic                 rx_valid_q;
  logic                 accept;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 wr_ok, rd_ok;
  logic                 fetch_oor;
  logic                 mem_we, mem_re;
  logic [MEM_AW-1:0]    mem_addr;
  logic [PAYLOAD_W-1:0] mem_rdata;
  logic                 load_dout, clr_tx;

  assign cmd     = spi_cmd_e'(din[SPI_WORD_W-1:PAYLOAD_W]);
  assign payload = din[PAYLOAD_W-1:0];
  assign accept  = rx_valid & ~rx_valid_q;
  assign wr_ok   = addr_in_range(wr_addr, MEM_DEPTH);
  assign rd_ok   = addr_in_range(rd_addr, MEM_DEPTH);

  // The read is launched on the accept cycle itself so the RAM's output
  // register already holds the word during FETCH; that register also pins
  // the address, so a later RD_ADDR cannot disturb an in-flight read.
  assign mem_we   = accept && (cmd == WR_DATA) && wr_ok;
  assign mem_re   = accept && (cmd == RD_DATA) && rd_ok;
  assign mem_addr = (cmd == WR_DATA) ? wr_addr[MEM_AW-1:0] : rd_addr[MEM_AW-1:0];

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (mem_rdata)
  );

  // rx_valid delay for rising-edge detection; cleared so a word held across
  // reset release still counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_valid_q <= 1'b0;
    else     rx_valid_q <= rx_valid;
  end

  // Address registers updated by accepted address/data commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (accept) begin
      case (cmd)
        WR_ADDR: wr_addr <= payload;
        WR_DATA: if (WR_AUTOINC) wr_addr <= (wr_addr == WRAP_ADDR) ? '0 : wr_addr + ADDR_SIZE'(1);
        RD_ADDR: rd_addr <= payload;
        default: ;
      endcase
    end
  end

  // Remembers whether the in-flight read targeted a non-existent word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            fetch_oor <= 1'b0;
    else if (accept && cmd == RD_DATA)  fetch_oor <= ~rd_ok;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RC_IDLE;
    else     state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      RC_IDLE:  if (accept && cmd == RD_DATA) next_state = RC_FETCH;
      RC_FETCH: next_state = RC_HOLD;
      RC_HOLD:  if (accept) next_state = (cmd == RD_DATA) ? RC_FETCH : RC_IDLE;
      default:  next_state = RC_IDLE;
    endcase
  end

  // FSM output decode: load the result leaving FETCH, drop valid on leaving HOLD.
  always_comb begin
    load_dout = 1'b0;
    clr_tx    = 1'b0;
    if (state == RC_FETCH)          load_dout = 1'b1;
    if (state == RC_HOLD && accept) clr_tx    = 1'b1;
  end

  // Output registers; dout is left untouched after HOLD so it stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
    end else if (load_dout) begin
      dout     <= fetch_oor ? '0 : mem_rdata;
      tx_valid <= 1'b1;
    end else if (clr_tx) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three parameterisations share one stimulus stream;
// each is checked every cycle against a command-level model, plus directed
// table entries with hand-computed expected results.
module tb_spi_ram_ctrl;

  localparam int NI = 3;

  int dep[NI]  = '{256, 256, 128};
  bit ainc[NI] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] d0, d1, d2;
  logic       t0, t1, t2;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .WR_AUTOINC(1'b0)) u0 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(d0), .tx_valid(t0));
  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .WR_AUTOINC(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(d1), .tx_valid(t1));
  spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .WR_AUTOINC(1'b0)) u2 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(d2), .tx_valid(t2));

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] mmem[NI][256];
  bit         mknown[NI][256];
  logic [7:0] wa[NI], ra[NI];
  bit         mq;
  bit         pend[NI];
  logic [7:0] pval[NI];
  bit         pknown[NI];
  bit         etx[NI];
  logic [7:0] edout[NI];
  bit         eknown[NI];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [9:0] w;
    int         hold;
    int         inst;
    bit         chk;
    bit         tx;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] get_d(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic get_t(input int i);
    case (i)
      0:       return t0;
      1:       return t1;
      default: return t2;
    endcase
  endfunction

  task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @%0t: got %h want %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq = 1'b0;
    for (int i = 0; i < NI; i++) begin
      wa[i] = '0; ra[i] = '0; pend[i] = 1'b0;
      etx[i] = 1'b0; edout[i] = '0; eknown[i] = 1'b1;
    end
  endtask

  // One clock of the command-level model, evaluated right after a rising edge.
  task automatic model_step();
    bit acc;
    if (rst) return;
    acc = rx_valid && !mq;
    mq  = rx_valid;
    for (int i = 0; i < NI; i++) begin
      if (pend[i]) begin
        etx[i] = 1'b1; edout[i] = pval[i]; eknown[i] = pknown[i]; pend[i] = 1'b0;
      end
      if (acc) begin
        etx[i] = 1'b0;
        case (din[9:8])
          2'd0: wa[i] = din[7:0];
          2'd1: begin
            if (int'(wa[i]) < dep[i]) begin
              mmem[i][wa[i]] = din[7:0];
              mknown[i][wa[i]] = 1'b1;
            end
            if (ainc[i]) wa[i] = (int'(wa[i]) == dep[i] - 1) ? 8'h00 : wa[i] + 8'h01;
          end
          2'd2: ra[i] = din[7:0];
          default: begin
            pend[i] = 1'b1;
            if (int'(ra[i]) < dep[i]) begin
              pval[i] = mmem[i][ra[i]]; pknown[i] = mknown[i][ra[i]];
            end else begin
              pval[i] = 8'h00; pknown[i] = 1'b1;
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk("tx_valid", i, {7'b0, get_t(i)}, {7'b0, etx[i]});
      if (eknown[i]) chk("dout", i, get_d(i), edout[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge; rx_valid high for 'hold' cycles then low for 'gap'.
  task automatic send(input logic [9:0] w, input int hold, input int gap);
    din = w;
    rx_valid = 1'b1;
    for (int k = 0; k < hold + gap; k++) begin
      if (k == hold) rx_valid = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] p;

    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) mknown[i][a] = 1'b0;
    model_reset();

    // power-on reset, released with rx_valid low
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // basic write/read
    tbl.push_back('{10'h0A3, 3, 0, 0, 0, 8'h00});
    tbl.push_back('{10'h15C, 3, 0, 0, 0, 8'h00});
    tbl.push_back('{10'h2A3, 3, 0, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 3, 0, 1, 1, 8'h5C});
    // auto-increment with wrap
    tbl.push_back('{10'h0FF, 3, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h111, 3, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h122, 3, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h2FF, 3, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 3, 1, 1, 1, 8'h11});
    tbl.push_back('{10'h200, 3, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 3, 1, 1, 1, 8'h22});
    // long rx_valid: one write only, address advances by one
    tbl.push_back('{10'h012, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h1C3, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h010, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h1AA, 12, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h1BB, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h210, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 2, 1, 1, 1, 8'hAA});
    tbl.push_back('{10'h211, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 2, 1, 1, 1, 8'hBB});
    tbl.push_back('{10'h212, 2, 1, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 2, 1, 1, 1, 8'hC3});
    // out-of-range on the 128-deep instance, in range on the 256-deep one
    tbl.push_back('{10'h090, 3, 2, 0, 0, 8'h00});
    tbl.push_back('{10'h177, 3, 2, 0, 0, 8'h00});
    tbl.push_back('{10'h290, 3, 2, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 3, 2, 1, 1, 8'h00});
    tbl.push_back('{10'h300, 3, 0, 1, 1, 8'h77});
    // park instance 0 in HOLD with 0x5C before the reset sequence
    tbl.push_back('{10'h2A3, 3, 0, 0, 0, 8'h00});
    tbl.push_back('{10'h300, 3, 0, 1, 1, 8'h5C});

    foreach (tbl[n]) begin
      send(tbl[n].w, tbl[n].hold, 1);
      if (tbl[n].chk) begin
        chk("tbl_tx", tbl[n].inst, {7'b0, get_t(tbl[n].inst)}, {7'b0, tbl[n].tx});
        chk("tbl_dout", tbl[n].inst, get_d(tbl[n].inst), tbl[n].d);
      end
    end

    // async reset mid-HOLD, with a RD_DATA word held across the release
    #2;
    rst = 1'b1;
    din = 10'h300;
    rx_valid = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_async_tx", i, {7'b0, get_t(i)}, 8'h00);
      chk("rst_async_dout", i, get_d(i), 8'h00);
    end
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_tx", 1, {7'b0, get_t(1)}, 8'h01);
    chk("post_rst_dout", 1, get_d(1), 8'h22);
    rx_valid = 1'b0;
    tick();

    // randomized command stream
    for (int n = 0; n < 400; n++) begin
      op = 2'($urandom_range(0, 3));
      p  = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) p = p | 8'h80;
      send({op, p}, $urandom_range(1, 5), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
